// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset release sequencer:
//   - seq_state_t    : sequencer FSM state encoding (3 bits)
//   - DLY_W          : width of the shared delay/timeout counter
//   - DEF_*          : default values for the sequencer parameters
// Optional feature macro used by the importing files: RST_SEQ_TIMEOUT_EN
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } seq_state_t;

    localparam int DLY_W          = 8;
    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_STAGE_DLY  = 16;
    localparam int DEF_TIMEOUT    = 255;

endpackage : rst_seq_pkg

// File: rtl/rst_seq_mux2.sv
// -----------------------------------------------------------------------------
// rst_seq_mux2
// Single-bit MUX2 cell used for the scan bypass of each reset output. It is
// kept as a discrete cell so the reset path stays a known, controllable gate
// in test mode rather than being merged into surrounding logic.
// Ports:
//   i_a    in   selected when i_sel = 0
//   i_b    in   selected when i_sel = 1
//   i_sel  in   select
//   o_y    out  mux output
// -----------------------------------------------------------------------------
module rst_seq_mux2 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule : rst_seq_mux2

// File: rtl/rst_seq_timer.sv
// -----------------------------------------------------------------------------
// rst_seq_timer
// 8-bit load/clear/increment counter with a terminal-count flag. The
// sequencer shares one instance between its settle delay and its
// acknowledge timeout by switching the terminal value.
// Ports:
//   sysclk             in   clock
//   I_reset_event_rstn in   asynchronous active-low reset
//   i_clear            in   synchronous clear (highest priority)
//   i_load             in   synchronous load of i_load_val
//   i_load_val         in   DLY_W load value
//   i_inc              in   increment enable
//   i_tc_val           in   DLY_W terminal-count value
//   o_tc               out  count equals i_tc_val
// -----------------------------------------------------------------------------
module rst_seq_timer
    import rst_seq_pkg::*;
(
    input  logic             sysclk,
    input  logic             I_reset_event_rstn,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [DLY_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic [DLY_W-1:0] i_tc_val,
    output logic             o_tc
);

    logic [DLY_W-1:0] r_count;

    // Clear wins over load, load wins over increment.
    always_ff @(posedge sysclk or negedge I_reset_event_rstn) begin
        if (!I_reset_event_rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= r_count + DLY_W'(1);
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule : rst_seq_timer

// File: rtl/reset_release_sequencer.sv
// -----------------------------------------------------------------------------
// reset_release_sequencer
// Releases NUM_STAGES downstream reset domains one at a time after the
// reset-event reset deasserts. Each stage is released STAGE_DLY edges after
// the previous stage acknowledged (or after reset release for stage 0), and
// the next stage waits for the current stage's acknowledge. A rerun request
// in DONE/ERR drops all stages and restarts the sequence. In scan test mode
// every reset output is driven by ATPG_RSTN through a MUX2 cell.
//
// Optional feature macro: RST_SEQ_TIMEOUT_EN
//   defined   : WAIT_ACK times out after TIMEOUT, entering ERR and reporting
//               seq_err / err_stage
//   undefined : WAIT_ACK waits indefinitely, seq_err / err_stage tied to 0
//
// Ports:
//   sysclk             in   system clock
//   I_reset_event_rstn in   asynchronous active-low reset
//   ATPG_TM            in   scan test mode
//   ATPG_RSTN          in   scan reset, drives all outputs when ATPG_TM=1
//   stage_ack          in   NUM_STAGES per-stage acknowledge
//   sw_rerun           in   single-cycle rerun request
//   stage_rstn         out  NUM_STAGES sequenced active-low resets
//   seq_done           out  all stages released and acknowledged
//   seq_err            out  acknowledge timeout occurred
//   err_stage          out  STG_W index of the timed-out stage
// -----------------------------------------------------------------------------
module reset_release_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int STAGE_DLY  = DEF_STAGE_DLY,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int STG_W      = $clog2(NUM_STAGES)
) (
    input  logic                  sysclk,
    input  logic                  I_reset_event_rstn,
    input  logic                  ATPG_TM,
    input  logic                  ATPG_RSTN,
    input  logic [NUM_STAGES-1:0] stage_ack,
    input  logic                  sw_rerun,
    output logic [NUM_STAGES-1:0] stage_rstn,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic [STG_W-1:0]      err_stage
);

    seq_state_t            r_state;
    logic [STG_W-1:0]      r_k;
    logic [NUM_STAGES-1:0] r_stage_rstn;
    logic                  r_seq_done;

    logic                  w_ack_k;
    logic                  w_last;
    logic                  w_tc;
    logic                  w_clear;
    logic                  w_inc;
    logic [DLY_W-1:0]      w_tc_val;

    assign w_ack_k = stage_ack[r_k];
    assign w_last  = (r_k == STG_W'(NUM_STAGES - 1));

    // The shared timer counts the settle delay in DELAY and the acknowledge
    // wait in WAIT_ACK; only the terminal value differs.
    assign w_tc_val = (r_state == ST_WAIT_ACK) ? DLY_W'(TIMEOUT)
                                               : DLY_W'(STAGE_DLY - 1);

    // The counter restarts from zero whenever the FSM leaves a counting
    // state, so every DELAY and WAIT_ACK visit begins at count 0.
    always_comb begin
        w_clear = 1'b0;
        w_inc   = 1'b0;
        case (r_state)
            ST_DELAY: begin
                if (w_tc) w_clear = 1'b1;
                else      w_inc   = 1'b1;
            end
            ST_WAIT_ACK: begin
`ifdef RST_SEQ_TIMEOUT_EN
                if (w_ack_k || w_tc) w_clear = 1'b1;
                else                 w_inc   = 1'b1;
`else
                w_clear = w_ack_k;
`endif
            end
            default: w_clear = 1'b1;
        endcase
    end

    rst_seq_timer u_timer (
        .sysclk             (sysclk),
        .I_reset_event_rstn (I_reset_event_rstn),
        .i_clear            (w_clear),
        .i_load             (1'b0),
        .i_load_val         ('0),
        .i_inc              (w_inc),
        .i_tc_val           (w_tc_val),
        .o_tc               (w_tc)
    );

`ifdef RST_SEQ_TIMEOUT_EN
    logic             r_seq_err;
    logic [STG_W-1:0] r_err_stage;
`endif

    // Sequencer FSM. Released stages are only ever set here, in index order,
    // and are cleared together on rerun or asynchronously on reset.
    always_ff @(posedge sysclk or negedge I_reset_event_rstn) begin
        if (!I_reset_event_rstn) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_stage_rstn <= '0;
            r_seq_done   <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            r_seq_err    <= 1'b0;
            r_err_stage  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_DELAY;
                end
                ST_DELAY: begin
                    if (w_tc) begin
                        r_stage_rstn[r_k] <= 1'b1;
                        r_state           <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_ack_k) begin
                        if (w_last) begin
                            r_seq_done <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_k     <= r_k + STG_W'(1);
                            r_state <= ST_DELAY;
                        end
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (w_tc) begin
                        r_seq_err   <= 1'b1;
                        r_err_stage <= r_k;
                        r_state     <= ST_ERR;
                    end
`endif
                end
                ST_DONE, ST_ERR: begin
                    if (sw_rerun) begin
                        r_stage_rstn <= '0;
                        r_seq_done   <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
                        r_seq_err    <= 1'b0;
                        r_err_stage  <= '0;
`endif
                        r_k          <= '0;
                        r_state      <= ST_DELAY;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign seq_done = r_seq_done;

`ifdef RST_SEQ_TIMEOUT_EN
    assign seq_err   = r_seq_err;
    assign err_stage = r_err_stage;
`else
    assign seq_err   = 1'b0;
    assign err_stage = '0;
`endif

    // Scan bypass: one MUX2 cell per reset output.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_bypass
        rst_seq_mux2 u_mux (
            .i_a   (r_stage_rstn[gi]),
            .i_b   (ATPG_RSTN),
            .i_sel (ATPG_TM),
            .o_y   (stage_rstn[gi])
        );
    end

endmodule : reset_release_sequencer

// File: tb/tb_reset_release_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_release_sequencer
// Directed bench for reset_release_sequencer at default parameters
// (4 stages, settle delay 16, timeout 255). Edges are counted from reset
// release; outputs are sampled 1 time unit after each rising edge.
// Optional feature macro: RST_SEQ_TIMEOUT_EN selects the timeout expectation.
// -----------------------------------------------------------------------------
module tb_reset_release_sequencer;

    logic       sysclk = 1'b0;
    logic       I_reset_event_rstn = 1'b0;
    logic       ATPG_TM = 1'b0;
    logic       ATPG_RSTN = 1'b0;
    logic [3:0] stage_ack = 4'b0000;
    logic       sw_rerun = 1'b0;
    logic [3:0] stage_rstn;
    logic       seq_done;
    logic       seq_err;
    logic [1:0] err_stage;

    int checks = 0;
    int errors = 0;
    int edgeCount = 0;

    reset_release_sequencer dut (
        .sysclk             (sysclk),
        .I_reset_event_rstn (I_reset_event_rstn),
        .ATPG_TM            (ATPG_TM),
        .ATPG_RSTN          (ATPG_RSTN),
        .stage_ack          (stage_ack),
        .sw_rerun           (sw_rerun),
        .stage_rstn         (stage_rstn),
        .seq_done           (seq_done),
        .seq_err            (seq_err),
        .err_stage          (err_stage)
    );

    always #5 sysclk = ~sysclk;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at edge %0d",
                     tag, observed, expected, edgeCount);
        end
    endtask

    // Advance one rising edge and sample point.
    task automatic stepEdge();
        @(posedge sysclk);
        #1;
        edgeCount++;
    endtask

    task automatic runTo(input int target);
        while (edgeCount < target) stepEdge();
    endtask

    // Hold reset for a few cycles, then release between edges so the next
    // rising edge is edge 1.
    task automatic applyReset();
        I_reset_event_rstn = 1'b0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        I_reset_event_rstn = 1'b1;
        edgeCount = 0;
    endtask

    task automatic applyStimulus(input logic [3:0] acks, input logic rerun);
        stage_ack = acks;
        sw_rerun  = rerun;
    endtask

    initial begin
        // ---------------- reset values ----------------
        applyStimulus(4'b1111, 1'b0);
        I_reset_event_rstn = 1'b0;
        #12;
        checkOutput("reset_stage_rstn", 32'(stage_rstn), 32'h0);
        checkOutput("reset_seq_done",   32'(seq_done),   32'h0);
        checkOutput("reset_seq_err",    32'(seq_err),    32'h0);
        checkOutput("reset_err_stage",  32'(err_stage),  32'h0);

        // ---------------- nominal sequence, acks tied high ----------------
        applyReset();
        runTo(16); checkOutput("nom_e16", 32'(stage_rstn), 32'h0);
        runTo(17); checkOutput("nom_e17", 32'(stage_rstn), 32'h1);
        runTo(33); checkOutput("nom_e33", 32'(stage_rstn), 32'h1);
        runTo(34); checkOutput("nom_e34", 32'(stage_rstn), 32'h3);
        runTo(51); checkOutput("nom_e51", 32'(stage_rstn), 32'h7);
        runTo(68); checkOutput("nom_e68", 32'(stage_rstn), 32'hF);
        checkOutput("nom_done_e68", 32'(seq_done), 32'h0);
        runTo(69); checkOutput("nom_done_e69", 32'(seq_done), 32'h1);
        checkOutput("nom_err_e69", 32'(seq_err), 32'h0);

        // ---------------- rerun from DONE ----------------
        applyStimulus(4'b1111, 1'b1);
        stepEdge();                       // edge 70 samples the request
        applyStimulus(4'b1111, 1'b0);
        checkOutput("rerun_drop_rstn", 32'(stage_rstn), 32'h0);
        checkOutput("rerun_drop_done", 32'(seq_done),   32'h0);
        runTo(85); checkOutput("rerun_e85", 32'(stage_rstn), 32'h0);
        runTo(86); checkOutput("rerun_e86", 32'(stage_rstn), 32'h1);

        // Rerun during DELAY (stage 1 settling) must be ignored.
        runTo(89);
        applyStimulus(4'b1111, 1'b1);
        stepEdge();                       // edge 90
        applyStimulus(4'b1111, 1'b0);
        checkOutput("rerun_ign_e90", 32'(stage_rstn), 32'h1);
        runTo(102); checkOutput("rerun_ign_e102", 32'(stage_rstn), 32'h1);
        runTo(103); checkOutput("rerun_ign_e103", 32'(stage_rstn), 32'h3);
        runTo(138); checkOutput("rerun_ign_done", 32'(seq_done), 32'h1);
        checkOutput("rerun_ign_rstn", 32'(stage_rstn), 32'hF);

        // ---------------- delayed ack, wrong-stage ack, stall on stage 2 ----
        applyStimulus(4'b1001, 1'b0);
        applyReset();
        runTo(34); checkOutput("dly_e34", 32'(stage_rstn), 32'h3);
        runTo(99); checkOutput("dly_e99", 32'(stage_rstn), 32'h3);
        checkOutput("dly_done_e99", 32'(seq_done), 32'h0);
        applyStimulus(4'b1011, 1'b0);     // ack1 first sampled at edge 100
        runTo(115); checkOutput("dly_e115", 32'(stage_rstn), 32'h3);
        runTo(116); checkOutput("dly_e116", 32'(stage_rstn), 32'h7);
        runTo(200); checkOutput("stall_e200", 32'(stage_rstn), 32'h7);
        checkOutput("stall_done_e200", 32'(seq_done), 32'h0);
        runTo(380);
`ifdef RST_SEQ_TIMEOUT_EN
        checkOutput("tmo_err",       32'(seq_err),    32'h1);
        checkOutput("tmo_err_stage", 32'(err_stage),  32'h2);
        checkOutput("tmo_rstn",      32'(stage_rstn), 32'h7);
        checkOutput("tmo_done",      32'(seq_done),   32'h0);
`else
        checkOutput("notmo_err",  32'(seq_err),    32'h0);
        checkOutput("notmo_rstn", 32'(stage_rstn), 32'h7);
        checkOutput("notmo_done", 32'(seq_done),   32'h0);
`endif

        // ---------------- reset mid-sequence ----------------
        applyStimulus(4'b1111, 1'b0);
        applyReset();
        runTo(40); checkOutput("mid_e40", 32'(stage_rstn), 32'h3);
        #2;
        I_reset_event_rstn = 1'b0;
        #1;
        checkOutput("mid_async_rstn", 32'(stage_rstn), 32'h0);
        checkOutput("mid_async_done", 32'(seq_done),   32'h0);

        // ATPG bypass while the FSM is held in reset.
        ATPG_TM = 1'b1; ATPG_RSTN = 1'b1; #1;
        checkOutput("atpg_rst_hi", 32'(stage_rstn), 32'hF);
        ATPG_RSTN = 1'b0; #1;
        checkOutput("atpg_rst_lo", 32'(stage_rstn), 32'h0);
        ATPG_TM = 1'b0;

        applyReset();
        runTo(16); checkOutput("mid_restart_e16", 32'(stage_rstn), 32'h0);
        runTo(17); checkOutput("mid_restart_e17", 32'(stage_rstn), 32'h1);

        // ATPG bypass while the sequence is running.
        runTo(20);
        ATPG_TM = 1'b1; ATPG_RSTN = 1'b1; #1;
        checkOutput("atpg_run_hi", 32'(stage_rstn), 32'hF);
        ATPG_RSTN = 1'b0; #1;
        checkOutput("atpg_run_lo", 32'(stage_rstn), 32'h0);
        ATPG_RSTN = 1'b1; #1;
        checkOutput("atpg_run_hi2", 32'(stage_rstn), 32'hF);
        ATPG_TM = 1'b0; #1;
        checkOutput("atpg_run_off", 32'(stage_rstn), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reset_release_sequencer
